// File: rtl/gpr_pkg.sv
// Shared types and sizes for the GPR writeback path.
package gpr_pkg;
    localparam int REG_NUM  = 10;
    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 10;
    localparam int WB_DEPTH = 4;
    localparam int NUM_PUSH = 2;
    localparam int PTR_W    = $clog2(WB_DEPTH);
    localparam int CNT_W    = $clog2(WB_DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// In-order writeback queue: NUM_PUSH ordered push ports, one pop port.
module wb_fifo
    import gpr_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic      [NUM_PUSH-1:0] push_i,
    input  wb_entry_t [NUM_PUSH-1:0] push_entry_i,
    input  logic                     pop_i,
    output wb_entry_t                head_o,
    output logic      [CNT_W-1:0]    count_o
);
    wb_entry_t        mem_q [WB_DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d, n_push;
    logic [PTR_W-1:0] slot [NUM_PUSH];

    // Lower-numbered ports take the earlier slots, so port 0 is popped first.
    always_comb begin
        n_push = '0;
        for (int i = 0; i < NUM_PUSH; i++) begin
            slot[i] = wptr_q + PTR_W'(n_push);
            n_push  = n_push + CNT_W'(push_i[i]);
        end
        wptr_d  = wptr_q + PTR_W'(n_push);
        rptr_d  = rptr_q + PTR_W'(pop_i);
        count_d = count_q + n_push - CNT_W'(pop_i);
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PUSH; i++)
            if (push_i[i]) mem_q[slot[i]] <= push_entry_i[i];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    assign head_o  = mem_q[rptr_q];
    assign count_o = count_q;
endmodule

// File: rtl/gpr_writeback.sv
// Merges ALU and load results into one registered GPR write port.
module gpr_writeback
    import gpr_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              write,
    output logic [ADDR_W-1:0] inaddr,
    output logic [DATA_W-1:0] indata,
    output logic [CNT_W-1:0]  pending,
    output logic              busy,
    output logic              addr_err,
    input  logic              clr_err
);
    wb_entry_t                head;
    logic      [CNT_W-1:0]    count;
    wb_entry_t [NUM_PUSH-1:0] entry;
    logic      [NUM_PUSH-1:0] xfer, addr_ok, push;
    logic                     pop, err_d;
    logic                     write_q;
    logic      [ADDR_W-1:0]   inaddr_q;
    logic      [DATA_W-1:0]   indata_q;
    logic                     err_q;

    // MEM yields the last free slot to ALU so two pushes never overflow.
    assign alu_ready = count < CNT_W'(WB_DEPTH);
    assign mem_ready = (count < CNT_W'(WB_DEPTH - 1)) ||
                       ((count == CNT_W'(WB_DEPTH - 1)) && !alu_valid);

    assign entry[0] = '{addr: alu_addr, data: alu_data};
    assign entry[1] = '{addr: mem_addr, data: mem_data};
    assign xfer     = {mem_valid & mem_ready, alu_valid & alu_ready};

    for (genvar i = 0; i < NUM_PUSH; i++) begin : g_chk
        assign addr_ok[i] = entry[i].addr < ADDR_W'(REG_NUM);
        assign push[i]    = xfer[i] & addr_ok[i];
    end

    assign pop   = count != '0;
    assign err_d = (|(xfer & ~addr_ok)) ? 1'b1 : (clr_err ? 1'b0 : err_q);

    wb_fifo u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .push_entry_i (entry),
        .pop_i        (pop),
        .head_o       (head),
        .count_o      (count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            write_q  <= 1'b0;
            inaddr_q <= '0;
            indata_q <= '0;
            err_q    <= 1'b0;
        end else begin
            write_q  <= pop;
            inaddr_q <= pop ? head.addr : '0;
            indata_q <= pop ? head.data : '0;
            err_q    <= err_d;
        end
    end

    assign write    = write_q;
    assign inaddr   = inaddr_q;
    assign indata   = indata_q;
    assign pending  = count;
    assign busy     = (count != '0) || write_q;
    assign addr_err = err_q;
endmodule

// File: tb/tb_gpr_writeback.sv
// Directed table-driven bench for gpr_writeback plus reset-mid-drain sequence.
module tb_gpr_writeback;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       alu_valid = 1'b0, mem_valid = 1'b0, clr_err = 1'b0;
    logic [3:0] alu_addr = '0, mem_addr = '0;
    logic [9:0] alu_data = '0, mem_data = '0;
    logic       alu_ready, mem_ready, write, busy, addr_err;
    logic [3:0] inaddr;
    logic [9:0] indata;
    logic [2:0] pending;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gpr_writeback dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .write(write), .inaddr(inaddr), .indata(indata),
        .pending(pending), .busy(busy), .addr_err(addr_err), .clr_err(clr_err)
    );

    typedef struct {
        bit av; int aa; int ad;
        bit mv; int ma; int md;
        bit ce;
        bit ear; bit emr;
        bit ew; int eia; int eid; int ep; bit eerr; bit ebusy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit av, int aa, int ad, bit mv, int ma, int md, bit ce,
                                bit ear, bit emr, bit ew, int eia, int eid, int ep,
                                bit eerr, bit ebusy);
        vec_t v;
        v.av = av; v.aa = aa; v.ad = ad; v.mv = mv; v.ma = ma; v.md = md; v.ce = ce;
        v.ear = ear; v.emr = emr; v.ew = ew; v.eia = eia; v.eid = eid; v.ep = ep;
        v.eerr = eerr; v.ebusy = ebusy;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit av, input int aa, input int ad,
                         input bit mv, input int ma, input int md, input bit ce);
        alu_valid = av; alu_addr = aa[3:0]; alu_data = ad[9:0];
        mem_valid = mv; mem_addr = ma[3:0]; mem_data = md[9:0];
        clr_err = ce;
    endtask

    task automatic chk_outs(input string tag, input bit ew, input int eia, input int eid,
                            input int ep, input bit eerr, input bit ebusy);
        chk({tag, ".write"},    int'(write),    int'(ew));
        chk({tag, ".inaddr"},   int'(inaddr),   eia);
        chk({tag, ".indata"},   int'(indata),   eid);
        chk({tag, ".pending"},  int'(pending),  ep);
        chk({tag, ".addr_err"}, int'(addr_err), int'(eerr));
        chk({tag, ".busy"},     int'(busy),     int'(ebusy));
    endtask

    // Inputs change 1 time unit after a rising edge; readies sampled mid-cycle.
    task automatic apply(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("v%0d", idx);
        drive(v.av, v.aa, v.ad, v.mv, v.ma, v.md, v.ce);
        #2;
        chk({tag, ".alu_ready"}, int'(alu_ready), int'(v.ear));
        chk({tag, ".mem_ready"}, int'(mem_ready), int'(v.emr));
        @(posedge clk); #1;
        chk_outs(tag, v.ew, v.eia, v.eid, v.ep, v.eerr, v.ebusy);
    endtask

    initial begin
        // single ALU push, one cycle latency
        vecs.push_back(mk(1,3,5,   0,0,0,  0, 1,1, 0,0,0, 1, 0,1));
        vecs.push_back(mk(0,0,0,   0,0,0,  0, 1,1, 1,3,5, 0, 0,1));
        vecs.push_back(mk(0,0,0,   0,0,0,  0, 1,1, 0,0,0, 0, 0,0));
        // simultaneous pushes, same address: ALU first, MEM last
        vecs.push_back(mk(1,6,7,   1,6,9,  0, 1,1, 0,0,0, 2, 0,1));
        vecs.push_back(mk(0,0,0,   0,0,0,  0, 1,1, 1,6,7, 1, 0,1));
        vecs.push_back(mk(0,0,0,   0,0,0,  0, 1,1, 1,6,9, 0, 0,1));
        vecs.push_back(mk(0,0,0,   0,0,0,  0, 1,1, 0,0,0, 0, 0,0));
        // bad addresses and sticky error
        vecs.push_back(mk(1,12,1,  0,0,0,  0, 1,1, 0,0,0, 0, 1,0));
        vecs.push_back(mk(0,0,0,   0,0,0,  0, 1,1, 0,0,0, 0, 1,0));
        vecs.push_back(mk(0,0,0,   0,0,0,  1, 1,1, 0,0,0, 0, 0,0));
        vecs.push_back(mk(1,12,2,  0,0,0,  1, 1,1, 0,0,0, 0, 1,0));
        vecs.push_back(mk(0,0,0,   0,0,0,  1, 1,1, 0,0,0, 0, 0,0));
        vecs.push_back(mk(0,0,0,   1,10,3, 0, 1,1, 0,0,0, 0, 1,0));
        vecs.push_back(mk(1,9,4,   0,0,0,  1, 1,1, 0,0,0, 1, 0,1));
        vecs.push_back(mk(0,0,0,   0,0,0,  0, 1,1, 1,9,4, 0, 0,1));
        vecs.push_back(mk(0,0,0,   0,0,0,  0, 1,1, 0,0,0, 0, 0,0));
        // saturate at pending 3: MEM held off while ALU valid
        vecs.push_back(mk(1,1,11,  1,2,12, 0, 1,1, 0,0,0,  2, 0,1));
        vecs.push_back(mk(1,3,13,  1,4,14, 0, 1,1, 1,1,11, 3, 0,1));
        vecs.push_back(mk(1,5,15,  1,6,16, 0, 1,0, 1,2,12, 3, 0,1));
        vecs.push_back(mk(1,7,17,  1,6,16, 0, 1,0, 1,3,13, 3, 0,1));
        vecs.push_back(mk(0,0,0,   1,6,16, 0, 1,1, 1,4,14, 3, 0,1));
        vecs.push_back(mk(0,0,0,   0,0,0,  0, 1,1, 1,5,15, 2, 0,1));
        vecs.push_back(mk(0,0,0,   0,0,0,  0, 1,1, 1,7,17, 1, 0,1));
        vecs.push_back(mk(0,0,0,   0,0,0,  0, 1,1, 1,6,16, 0, 0,1));
        vecs.push_back(mk(0,0,0,   0,0,0,  0, 1,1, 0,0,0,  0, 0,0));
        // eight alternating back-to-back pushes, addr k data 100+k
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0)
                vecs.push_back(mk(1,k,100+k, 0,0,0, 0, 1,1,
                                  k > 0, k > 0 ? k-1 : 0, k > 0 ? 99+k : 0, 1, 0,1));
            else
                vecs.push_back(mk(0,0,0, 1,k,100+k, 0, 1,1, 1, k-1, 99+k, 1, 0,1));
        end
        vecs.push_back(mk(0,0,0,   0,0,0,  0, 1,1, 1,7,107, 0, 0,1));
        vecs.push_back(mk(0,0,0,   0,0,0,  0, 1,1, 0,0,0,   0, 0,0));

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.alu_ready", int'(alu_ready), 1);
        chk("rst.mem_ready", int'(mem_ready), 1);
        chk_outs("rst", 0, 0, 0, 0, 0, 0);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

        // four pushes, then reset mid-drain
        drive(1,0,1, 1,1,2, 0);
        @(posedge clk); #1;
        chk("mr.p1", int'(pending), 2);
        drive(1,2,3, 1,3,4, 0);
        @(posedge clk); #1;
        chk_outs("mr.p2", 1, 0, 1, 3, 0, 1);
        drive(0,0,0, 0,0,0, 0);
        #1;
        rst = 1'b0;
        #1;
        chk_outs("mr.rst", 0, 0, 0, 0, 0, 0);
        chk("mr.alu_ready", int'(alu_ready), 1);
        chk("mr.mem_ready", int'(mem_ready), 1);
        @(posedge clk); #1;
        chk_outs("mr.hold", 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk_outs($sformatf("mr.idle%0d", i), 0, 0, 0, 0, 0, 0);
        end
        drive(1,5,6, 0,0,0, 0);
        @(posedge clk); #1;
        chk_outs("mr.acc", 0, 0, 0, 1, 0, 1);
        drive(0,0,0, 0,0,0, 0);
        @(posedge clk); #1;
        chk_outs("mr.wr", 1, 5, 6, 0, 0, 1);
        @(posedge clk); #1;
        chk_outs("mr.end", 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
